// File: rtl/mem_stage.sv
// Memory stage: 256x8 data memory, output-port latch, return-address redirect
// and the MEM/WB pipeline register feeding write-back and fetch.
module mem_stage #(
  parameter int DEPTH = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en_regf_M,
  input  logic       wr_en_dmem_M,
  input  logic       rd_en_M,
  input  logic       out_port_sel_M,
  input  logic       is_ret_M,
  input  logic       mux_out_sel_M,
  input  logic [1:0] mux_rdata_sel_M,
  input  logic [7:0] alu_out_M,
  input  logic [7:0] RD2_M,
  input  logic [7:0] IN_PORT_M,
  input  logic [7:0] instr_M,
  input  logic [1:0] rd_M,
  input  logic [7:0] mem_addr_M,
  input  logic [7:0] mem_wd_M,
  output logic       wr_en_regf_W,
  output logic [1:0] rd_W,
  output logic [7:0] wb_data_W,
  output logic [7:0] instr_W,
  output logic [7:0] out_port,
  output logic       ret_valid_W,
  output logic [7:0] ret_pc_W
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata;
  logic [7:0] wb_next;
  logic [7:0] out_next;

  // Read is combinational from registered storage, so a same-cycle store is
  // not yet visible: loads naturally see pre-write contents.
  always_comb begin
    rdata = 8'h00;
    if (rd_en_M) rdata = mem[mem_addr_M];
  end

  always_comb begin
    wb_next = alu_out_M;
    unique case (mux_rdata_sel_M)
      2'b00: wb_next = alu_out_M;
      2'b01: wb_next = rdata;
      2'b10: wb_next = IN_PORT_M;
      2'b11: wb_next = RD2_M;
      default: wb_next = alu_out_M;
    endcase
  end

  always_comb begin
    out_next = mux_out_sel_M ? RD2_M : alu_out_M;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else if (wr_en_dmem_M) begin
      mem[mem_addr_M] <= mem_wd_M;
    end
  end

  // MEM/WB boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en_regf_W <= 1'b0;
      rd_W         <= 2'b00;
      wb_data_W    <= 8'h00;
      instr_W      <= 8'h00;
      out_port     <= 8'h00;
      ret_valid_W  <= 1'b0;
      ret_pc_W     <= 8'h00;
    end else begin
      wr_en_regf_W <= wr_en_regf_M;
      rd_W         <= rd_M;
      wb_data_W    <= wb_next;
      instr_W      <= instr_M;
      if (out_port_sel_M) out_port <= out_next;
      ret_valid_W <= is_ret_M && rd_en_M;
      if (is_ret_M && rd_en_M) ret_pc_W <= rdata;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reference model compared every cycle plus
// hand-computed literal checks on the documented scenarios.
module tb_mem_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en_regf_M, wr_en_dmem_M, rd_en_M, out_port_sel_M, is_ret_M;
  logic       mux_out_sel_M;
  logic [1:0] mux_rdata_sel_M, rd_M;
  logic [7:0] alu_out_M, RD2_M, IN_PORT_M, instr_M, mem_addr_M, mem_wd_M;
  logic       wr_en_regf_W, ret_valid_W;
  logic [1:0] rd_W;
  logic [7:0] wb_data_W, instr_W, out_port, ret_pc_W;

  int n_vec  = 0;
  int n_fail = 0;

  mem_stage #(.DEPTH(256)) dut (
    .clk(clk), .reset(reset),
    .wr_en_regf_M(wr_en_regf_M), .wr_en_dmem_M(wr_en_dmem_M), .rd_en_M(rd_en_M),
    .out_port_sel_M(out_port_sel_M), .is_ret_M(is_ret_M),
    .mux_out_sel_M(mux_out_sel_M), .mux_rdata_sel_M(mux_rdata_sel_M),
    .alu_out_M(alu_out_M), .RD2_M(RD2_M), .IN_PORT_M(IN_PORT_M), .instr_M(instr_M),
    .rd_M(rd_M), .mem_addr_M(mem_addr_M), .mem_wd_M(mem_wd_M),
    .wr_en_regf_W(wr_en_regf_W), .rd_W(rd_W), .wb_data_W(wb_data_W),
    .instr_W(instr_W), .out_port(out_port), .ret_valid_W(ret_valid_W),
    .ret_pc_W(ret_pc_W)
  );

  always #5 clk = ~clk;

  // Reference model: memory as a plain byte array, outputs as what the
  // stage should present after each edge.
  logic [7:0] m_mem [256];
  logic       e_wr, e_rv;
  logic [1:0] e_rd;
  logic [7:0] e_wb, e_instr, e_out, e_rpc;

  function automatic logic [7:0] m_read();
    return rd_en_M ? m_mem[mem_addr_M] : 8'h00;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) m_mem[i] <= 8'h00;
      e_wr <= 1'b0; e_rd <= 2'd0; e_wb <= 8'h00; e_instr <= 8'h00;
      e_out <= 8'h00; e_rv <= 1'b0; e_rpc <= 8'h00;
    end else begin
      e_wr    <= wr_en_regf_M;
      e_rd    <= rd_M;
      e_instr <= instr_M;
      case (mux_rdata_sel_M)
        2'd0: e_wb <= alu_out_M;
        2'd1: e_wb <= m_read();
        2'd2: e_wb <= IN_PORT_M;
        default: e_wb <= RD2_M;
      endcase
      if (out_port_sel_M) e_out <= mux_out_sel_M ? RD2_M : alu_out_M;
      e_rv <= is_ret_M & rd_en_M;
      if (is_ret_M & rd_en_M) e_rpc <= m_read();
      if (wr_en_dmem_M) m_mem[mem_addr_M] <= mem_wd_M;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_wr_en_regf", {7'd0, wr_en_regf_W}, {7'd0, e_wr});
    chk("m_rd", {6'd0, rd_W}, {6'd0, e_rd});
    chk("m_wb_data", wb_data_W, e_wb);
    chk("m_instr", instr_W, e_instr);
    chk("m_out_port", out_port, e_out);
    chk("m_ret_valid", {7'd0, ret_valid_W}, {7'd0, e_rv});
    chk("m_ret_pc", ret_pc_W, e_rpc);
  end

  task automatic idle();
    wr_en_regf_M = 0; wr_en_dmem_M = 0; rd_en_M = 0; out_port_sel_M = 0;
    is_ret_M = 0; mux_out_sel_M = 0; mux_rdata_sel_M = 2'd0; rd_M = 2'd0;
    alu_out_M = 8'h00; RD2_M = 8'h00; IN_PORT_M = 8'h00; instr_M = 8'h00;
    mem_addr_M = 8'h00; mem_wd_M = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [7:0] a, input logic [7:0] d);
    idle(); wr_en_dmem_M = 1; mem_addr_M = a; mem_wd_M = d;
    tick();
  endtask

  task automatic load(input logic [7:0] a);
    idle(); rd_en_M = 1; mem_addr_M = a; mux_rdata_sel_M = 2'd1;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    tick(); tick();
    chk("reset_wb", wb_data_W, 8'h00);
    chk("reset_out", out_port, 8'h00);
    reset = 1'b1;

    // store then load at the top address
    store(8'hFF, 8'h5C);
    idle(); rd_en_M = 1; mem_addr_M = 8'hFF; mux_rdata_sel_M = 2'd1;
    wr_en_regf_M = 1; rd_M = 2'd2; instr_M = 8'hA5;
    tick();
    chk("load_ff", wb_data_W, 8'h5C);
    chk("load_wr", {7'd0, wr_en_regf_W}, 8'h01);
    chk("load_rd", {6'd0, rd_W}, 8'h02);
    chk("load_instr", instr_W, 8'hA5);

    // read-before-write
    store(8'h20, 8'h11);
    idle(); rd_en_M = 1; wr_en_dmem_M = 1; mem_addr_M = 8'h20; mem_wd_M = 8'h22;
    mux_rdata_sel_M = 2'd1;
    tick();
    chk("rbw_old", wb_data_W, 8'h11);
    load(8'h20);
    chk("rbw_new", wb_data_W, 8'h22);

    // write-back source sweep
    store(8'h30, 8'h02);
    idle(); alu_out_M = 8'h01; IN_PORT_M = 8'h03; RD2_M = 8'h04;
    rd_en_M = 1; mem_addr_M = 8'h30;
    for (int s = 0; s < 4; s++) begin
      mux_rdata_sel_M = 2'(s);
      tick();
      chk("wb_sweep", wb_data_W, 8'(s + 1));
    end

    // output port latch and hold
    idle(); out_port_sel_M = 1; mux_out_sel_M = 1; RD2_M = 8'h7E; alu_out_M = 8'h55;
    tick();
    chk("out_set", out_port, 8'h7E);
    for (int k = 0; k < 5; k++) begin
      idle(); RD2_M = 8'(k * 17 + 3); alu_out_M = 8'(k * 29 + 9); mux_out_sel_M = k[0];
      tick();
      chk("out_hold", out_port, 8'h7E);
    end

    // return redirect
    store(8'hFE, 8'h3A);
    store(8'hFD, 8'h4B);
    idle(); is_ret_M = 1; rd_en_M = 1; mem_addr_M = 8'hFE;
    tick();
    chk("ret_valid", {7'd0, ret_valid_W}, 8'h01);
    chk("ret_pc", ret_pc_W, 8'h3A);
    idle(); tick();
    chk("ret_pulse_end", {7'd0, ret_valid_W}, 8'h00);
    chk("ret_pc_hold", ret_pc_W, 8'h3A);
    idle(); is_ret_M = 1; mem_addr_M = 8'hFD;
    tick();
    chk("ret_no_rd", {7'd0, ret_valid_W}, 8'h00);
    idle(); is_ret_M = 1; rd_en_M = 1; mem_addr_M = 8'hFE;
    tick();
    chk("ret_b2b_1", {7'd0, ret_valid_W}, 8'h01);
    chk("ret_b2b_1pc", ret_pc_W, 8'h3A);
    mem_addr_M = 8'hFD;
    tick();
    chk("ret_b2b_2", {7'd0, ret_valid_W}, 8'h01);
    chk("ret_b2b_2pc", ret_pc_W, 8'h4B);
    idle(); tick();
    chk("ret_b2b_end", {7'd0, ret_valid_W}, 8'h00);

    // simultaneous port update, store and load
    idle(); out_port_sel_M = 1; alu_out_M = 8'h66; wr_en_dmem_M = 1; rd_en_M = 1;
    mem_addr_M = 8'h40; mem_wd_M = 8'h99; mux_rdata_sel_M = 2'd1;
    tick();
    chk("sim_out", out_port, 8'h66);
    chk("sim_wb", wb_data_W, 8'h00);
    load(8'h40);
    chk("sim_load", wb_data_W, 8'h99);

    // asynchronous reset mid-cycle, with a store pending across the edge
    idle(); out_port_sel_M = 1; alu_out_M = 8'hAA;
    tick();
    chk("pre_rst_out", out_port, 8'hAA);
    #2 reset = 1'b0;
    #1;
    chk("rst_out", out_port, 8'h00);
    chk("rst_wb", wb_data_W, 8'h00);
    chk("rst_instr", instr_W, 8'h00);
    chk("rst_rpc", ret_pc_W, 8'h00);
    idle(); wr_en_dmem_M = 1; mem_addr_M = 8'h10; mem_wd_M = 8'h77;
    tick();
    reset = 1'b1;
    load(8'h10);
    chk("rst_load_10", wb_data_W, 8'h00);
    load(8'hFF);
    chk("rst_load_ff", wb_data_W, 8'h00);
    idle(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the 8-bit pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes its `_M` outputs. It owns the 256×8 data memory, the output-port latch and the return-address redirect. It also contains the MEM/WB pipeline register and presents registered `_W` results to the write-back stage and to the fetch unit.

## Interface
Parameters:
- `DEPTH`, 256: data memory depth in bytes. The address is 8 bits, so the full range is always used.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `wr_en_regf_M` in 1: instruction writes the register file.
- `wr_en_dmem_M` in 1: instruction stores to data memory.
- `rd_en_M` in 1: instruction loads from data memory.
- `out_port_sel_M` in 1: instruction updates the output port.
- `is_ret_M` in 1: instruction is RET/RTI (pops the PC).
- `mux_out_sel_M` in 1: output-port source; 0 = `alu_out_M`, 1 = `RD2_M`.
- `mux_rdata_sel_M` in 2: write-back source; 00 = `alu_out_M`, 01 = memory read data, 10 = `IN_PORT_M`, 11 = `RD2_M`.
- `alu_out_M`, `RD2_M`, `IN_PORT_M`, `instr_M` in 8 each: data from the EX/MEM register.
- `rd_M` in 2: destination register index.
- `mem_addr_M`, `mem_wd_M` in 8 each: memory address and store data.
- `wr_en_regf_W` out 1: registered write enable for write-back.
- `rd_W` out 2: registered destination index.
- `wb_data_W` out 8: registered write-back value.
- `instr_W` out 8: registered instruction, for debug and hazard logic.
- `out_port` out 8: output-port latch.
- `ret_valid_W` out 1: one-cycle pulse requesting a PC redirect.
- `ret_pc_W` out 8: popped return address; valid only while `ret_valid_W` = 1.

## Operation
- **Memory:** `mem[0..255]`, 8 bits per entry, fully registered.
  - Store: when `wr_en_dmem_M` = 1, `mem[mem_addr_M] <= mem_wd_M` at the edge.
  - Load: when `rd_en_M` = 1, the read value `rdata = mem[mem_addr_M]`.
  - Load and store in the same cycle to the same address (push/pop corner cases): the read returns the pre-write contents (read-before-write). The write still takes effect.
  - `rd_en_M` = 0: `rdata` is 8'h00.
- **MEM/WB register** (updates every edge; no stall or enable):
  - `wb_data_W <= mux(mux_rdata_sel_M)` over `{alu_out_M, rdata, IN_PORT_M, RD2_M}`.
  - `wr_en_regf_W <= wr_en_regf_M`, `rd_W <= rd_M`, `instr_W <= instr_M`.
- **Output port:**
  - When `out_port_sel_M` = 1, `out_port <= mux_out_sel_M ? RD2_M : alu_out_M`.
  - Otherwise `out_port` holds its value indefinitely.
- **Return redirect:**
  - When `is_ret_M` = 1 and `rd_en_M` = 1: `ret_valid_W <= 1` and `ret_pc_W <= rdata`.
  - Otherwise `ret_valid_W <= 0`; `ret_pc_W` holds its value.
  - `is_ret_M` with `rd_en_M` = 0 is illegal encoding and produces no pulse.
- No FSM beyond this. The stage is pure single-cycle; back-to-back instructions are accepted every cycle.
- **Widths:** all data paths are 8 bits with no arithmetic in this stage. `mem_addr_M` wraps naturally at 255 → 0 because no address logic exists here.

## Timing
- **Reset** (`reset` = 0, asynchronous, effective immediately):
  - `wr_en_regf_W` = 0, `rd_W` = 0, `wb_data_W` = 0, `instr_W` = 0.
  - `out_port` = 0, `ret_valid_W` = 0, `ret_pc_W` = 0.
  - All 256 memory bytes are cleared to 0.
- Reset asserted mid-operation discards any in-flight store; that edge performs no write. The first edge after release behaves normally.
- **Latency:**
  - `_M` inputs to `_W` outputs: 1 cycle.
  - Store to visibility: a load in the next cycle to the same address sees the new data.
  - `out_port` changes 1 cycle after the `out_port_sel_M` cycle.
  - `ret_valid_W` is high for exactly 1 cycle per RET. Fetch must redirect on that cycle.
- Simultaneous `out_port_sel_M`, `wr_en_dmem_M` and `rd_en_M` in one cycle are all honoured independently.

## Test plan
- **Reset:** drive `out_port_sel_M` = 1 with data 8'hAA, then assert `reset` = 0 mid-cycle → all `_W` outputs and `out_port` read 0 immediately; after release, a load of address 8'h10 returns 8'h00.
- **Store/load:** store 8'h5C to address 8'hFF; next cycle load 8'hFF with `mux_rdata_sel_M` = 01 → `wb_data_W` = 8'h5C one cycle later, and `wr_en_regf_W`/`rd_W` track their inputs.
- **Read-before-write:** `mem[8'h20]` = 8'h11; in one cycle store 8'h22 and load 8'h20 → `wb_data_W` = 8'h11; a load the next cycle → 8'h22.
- **Write-back mux sweep:** `alu_out_M` = 8'h01, `IN_PORT_M` = 8'h03, `RD2_M` = 8'h04, memory byte = 8'h02; sweep `mux_rdata_sel_M` 00..11 over four cycles → `wb_data_W` = 01, 02, 03, 04 respectively.
- **Output port:** `out_port_sel_M` = 1 with `mux_out_sel_M` = 1 and `RD2_M` = 8'h7E → `out_port` = 8'h7E; then hold `out_port_sel_M` = 0 for 5 cycles with changing data → `out_port` stays 8'h7E.
- **RET:**
  - With `mem[8'hFE]` = 8'h3A, `is_ret_M` = 1, `rd_en_M` = 1 and address 8'hFE for one cycle → `ret_valid_W` is a 1-cycle pulse with `ret_pc_W` = 8'h3A.
  - `is_ret_M` = 1 with `rd_en_M` = 0 → no pulse.
  - Back-to-back RETs → two consecutive pulses.
